gf_frobenius_sched: RTL

Shared iterated-squaring engine for the GF(2^13) BCH decoder. Up to NREQ requesters submit a field element `a` and an iteration count `k`. The block arbitrates round-robin, runs one squaring per cycle through a single squaring unit, and returns `a^(2^k)` tagged with the requester index. Syndrome expansion (S_2i = S_i^2) and Frobenius-power steps in the key-equation and Chien stages share this one squarer instead of each carrying its own.

---
 rtl/gf13_pkg.sv | 17 +
 rtl/gf_frobenius_sched_if.sv | 28 ++
 rtl/Square.sv | 26 ++
 rtl/gf_frobenius_sched.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gf13_pkg.sv
// Shared GF(2^13) definitions: field width, reduction polynomial, element type, scheduler states.
package gf13_pkg;

    localparam int unsigned GF_M = 13;

    // x^13 + x^4 + x^3 + x + 1
    localparam logic [GF_M:0] GF_POLY = 14'h201B;

    typedef logic [GF_M-1:0] gf13_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } frob_state_t;

endpackage

// File: rtl/gf_frobenius_sched_if.sv
// Request/response bus between the requesters and the shared squaring engine.
interface gf_frobenius_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned KW   = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    import gf13_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [GF_M*NREQ-1:0] req_data;
    logic [KW*NREQ-1:0]   req_k;
    logic                 rsp_valid;
    logic                 rsp_ready;
    gf13_t                rsp_data;
    logic [IDW-1:0]       rsp_id;

    modport master (
        output req_valid, req_data, req_k, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, req_k, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/Square.sv
// Combinational GF(2^13) squaring: spread bits to even positions, then fold the high half down.
module Square
    import gf13_pkg::*;
(
    input  gf13_t a,
    output gf13_t y
);

    function automatic gf13_t gf_sq(input gf13_t x);
        logic [2*GF_M-2:0] p;
        p = '0;
        for (int unsigned i = 0; i < GF_M; i++) begin
            p[2*i] = x[i];
        end
        // Clear bits 24..13 from the top, each fold may set lower bits still to be visited.
        for (int j = 2*GF_M-2; j >= int'(GF_M); j--) begin
            if (p[j]) begin
                p[j -: GF_M+1] = p[j -: GF_M+1] ^ GF_POLY;
            end
        end
        return p[GF_M-1:0];
    endfunction

    assign y = gf_sq(a);

endmodule

// File: rtl/gf_frobenius_sched.sv
// Round-robin shared iterated-squaring engine: returns a^(2^k) tagged with the requester index.
module gf_frobenius_sched
    import gf13_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned KW   = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    gf_frobenius_sched_if.slave bus
);

    frob_state_t     state_q, state_d;
    gf13_t           acc_q, acc_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  last_q, last_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            grant_vld_c;
    logic [IDW-1:0]  grant_idx_c;
    logic [IDW-1:0]  cand_c;
    logic [NREQ-1:0] grant_c;
    gf13_t           grant_data_c;
    logic [KW-1:0]   grant_k_c;
    logic            accept_c;
    gf13_t           sq_acc_c;

    Square u_square (
        .a (acc_q),
        .y (sq_acc_c)
    );

    // Round-robin pick: first valid requester searching upward from last+1, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand_c = IDW'((32'(last_q) + off) % NREQ);
            if (!grant_vld_c && bus.req_valid[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    // One-hot grant and payload of the picked requester.
    always_comb begin
        grant_c      = '0;
        grant_data_c = '0;
        grant_k_c    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_vld_c && (grant_idx_c == IDW'(i))) begin
                grant_c[i]   = 1'b1;
                grant_data_c = bus.req_data[GF_M*i +: GF_M];
                grant_k_c    = bus.req_k[KW*i +: KW];
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == IDLE)) begin
            bus.req_ready = grant_c;
        end
    end

    assign accept_c = |(bus.req_valid & bus.req_ready);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (grant_k_c == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == KW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, square-and-count in BUSY, release on handshake.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    acc_d       = grant_data_c;
                    cnt_d       = grant_k_c;
                    id_d        = grant_idx_c;
                    last_d      = grant_idx_c;
                    rsp_valid_d = (grant_k_c == '0);
                end
            end
            BUSY: begin
                acc_d = sq_acc_c;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: rsp_valid_d = 1'b0;
        endcase
    end

    // Datapath registers; last resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            last_q      <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = acc_q;
    assign bus.rsp_id    = id_q;

endmodule
